// File: rtl/apb_req_master.sv
// APB3 initiator: single-outstanding req/gnt/rvalid port to APB SETUP/ACCESS.
// A programmable ACCESS-cycle budget aborts transfers to hung slaves.
module apb_req_master #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [31:0]               addr_i,
  input  logic [31:0]               wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [31:0]               rdata_o,
  output logic                      err_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ?
    $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT =
    CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CMAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  state_e                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [31:0]               pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic                      psel_q, penable_q;
  logic                      rvalid_q, rvalid_d;
  logic [31:0]               rdata_q, rdata_d;
  logic                      err_q, err_d;

  generate
    if (APB_ADDR_WIDTH < 32) begin : g_trunc
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr_i[31:APB_ADDR_WIDTH];
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    gnt_o    = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_o = req_i;
        if (req_i) begin
          paddr_d  = addr_i[APB_ADDR_WIDTH-1:0];
          pwdata_d = wdata_i;
          pwrite_d = we_i;
          cnt_d    = '0;
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (!PREADY && cnt_q != CMAX)
          cnt_d = cnt_q + 1'b1;
        // completion beats the timeout when both land together
        if (PREADY) begin
          rvalid_d = 1'b1;
          err_d    = PSLVERR;
          rdata_d  = pwrite_q ? 32'h0 : PRDATA;
          state_d  = IDLE;
        end else if (TIMEOUT_CYCLES > 0 && cnt_q == LIMIT) begin
          rvalid_d = 1'b1;
          err_d    = 1'b1;
          rdata_d  = 32'h0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= (state_d != IDLE);
      penable_q <= (state_d == ACCESS);
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign PADDR    = paddr_q;
  assign PWDATA   = pwdata_q;
  assign PWRITE   = pwrite_q;
  assign PSEL     = psel_q;
  assign PENABLE  = penable_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_apb_req_master.sv
// Bench for apb_req_master: directed transfers plus randomized traffic,
// all cycles compared against a transfer-level model.
module tb_apb_req_master;

  localparam int T = 4;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        gnt_o, rvalid_o, err_o;
  logic [31:0] rdata_o;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;

  int checks = 0;
  int failures = 0;

  apb_req_master #(
    .APB_ADDR_WIDTH(12),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge HCLK);
    #1;
  endtask

  // Transfer-level model: age counts cycles since the grant (-1 = no
  // transfer); ACCESS begins at age 2 and each stalled cycle adds one.
  int          age = -1;
  bit          pend = 1'b0;
  bit          e_gnt;
  logic [31:0] m_rdata = '0;
  logic        m_err = 1'b0;
  logic [11:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic        m_we = 1'b0;

  initial forever begin
    @(negedge HCLK);
    if (!HRESETn) begin
      age = -1; pend = 1'b0;
      m_rdata = '0; m_err = 1'b0;
      m_addr = '0; m_wdata = '0; m_we = 1'b0;
    end
    e_gnt = (age < 0) && req_i;
    chk("m_gnt", 32'(gnt_o), 32'(e_gnt));
    chk("m_psel", 32'(PSEL), 32'(age >= 1));
    chk("m_penable", 32'(PENABLE), 32'(age >= 2));
    chk("m_rvalid", 32'(rvalid_o), 32'(pend));
    chk("m_rdata", rdata_o, m_rdata);
    if (pend) chk("m_err", 32'(err_o), 32'(m_err));
    chk("m_paddr", 32'(PADDR), 32'(m_addr));
    chk("m_pwdata", PWDATA, m_wdata);
    chk("m_pwrite", 32'(PWRITE), 32'(m_we));
    pend = 1'b0;
    if (HRESETn) begin
      if (e_gnt) begin
        age = 1;
        m_addr = addr_i[11:0];
        m_wdata = wdata_i;
        m_we = we_i;
      end else if (age == 1) begin
        age = 2;
      end else if (age >= 2) begin
        if (PREADY) begin
          pend = 1'b1;
          m_err = PSLVERR;
          m_rdata = m_we ? 32'h0 : PRDATA;
          age = -1;
        end else if (age - 2 == T - 1) begin
          pend = 1'b1;
          m_err = 1'b1;
          m_rdata = 32'h0;
          age = -1;
        end else begin
          age++;
        end
      end
    end
  end

  // One transfer; waits>=99 means the slave never answers.
  task automatic xfer(input logic w, input logic [31:0] a,
                      input logic [31:0] d, input int waits,
                      input logic [31:0] prd, input logic se,
                      input logic [31:0] er, input logic ee,
                      input int eacc);
    int n;
    req_i = 1'b1; we_i = w; addr_i = a; wdata_i = d;
    PREADY = 1'b0; PSLVERR = 1'b0;
    @(negedge HCLK);
    chk("gnt", 32'(gnt_o), 32'd1);
    nxt();
    req_i = 1'b0;
    @(negedge HCLK);
    chk("setup_psel", 32'(PSEL), 32'd1);
    chk("setup_penable", 32'(PENABLE), 32'd0);
    chk("setup_paddr", 32'(PADDR), 32'(a[11:0]));
    chk("setup_pwdata", PWDATA, d);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      nxt();
      PREADY = (k == waits);
      PRDATA = prd;
      PSLVERR = se;
      @(negedge HCLK);
      if (!(PSEL && PENABLE)) break;
      n++;
      chk("acc_paddr", 32'(PADDR), 32'(a[11:0]));
    end
    chk("acc_cycles", 32'(n), 32'(eacc));
    chk("resp_psel", 32'(PSEL), 32'd0);
    chk("resp_rvalid", 32'(rvalid_o), 32'd1);
    chk("resp_err", 32'(err_o), 32'(ee));
    chk("resp_rdata", rdata_o, er);
    nxt();
    PREADY = 1'b0;
    PSLVERR = 1'b0;
  endtask

  initial begin
    @(negedge HCLK);
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_rvalid", 32'(rvalid_o), 32'd0);
    chk("rst_paddr", 32'(PADDR), 32'd0);
    #7 HRESETn = 1'b1;
    nxt();

    xfer(1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 0,
         32'h1111_2222, 1'b0, 32'h0, 1'b0, 1);
    xfer(1'b0, 32'h0000_0010, 32'h0, 3,
         32'h0000_8000, 1'b0, 32'h0000_8000, 1'b0, 4);
    xfer(1'b0, 32'hFFFF_F044, 32'h0, 0,
         32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 1);
    xfer(1'b0, 32'h0000_0020, 32'h0, 99,
         32'h7777_7777, 1'b0, 32'h0, 1'b1, T);
    xfer(1'b0, 32'h0000_0024, 32'h0, 1,
         32'h5A5A_0001, 1'b0, 32'h5A5A_0001, 1'b0, 2);

    begin : b2b
      int g[$];
      int r[$];
      logic [31:0] eq[$];
      int ng;
      ng = 0;
      PREADY = 1'b1;
      PSLVERR = 1'b0;
      for (int c = 0; c < 20 && r.size() < 4; c++) begin
        if (ng < 4) begin
          req_i = 1'b1;
          we_i = (ng % 2 == 0);
          addr_i = 32'(32'h100 + ng * 4);
          wdata_i = 32'(32'hAB00_0000 + ng);
        end else begin
          req_i = 1'b0;
        end
        PRDATA = 32'hC0DE_0000 | {20'h0, PADDR};
        @(negedge HCLK);
        if (rvalid_o) begin
          r.push_back(c);
          if (eq.size() == 0) chk("b2b_extra", 32'd1, 32'd0);
          else chk("b2b_rdata", rdata_o, eq.pop_front());
        end
        if (gnt_o) begin
          g.push_back(c);
          eq.push_back(we_i ? 32'h0 : (32'hC0DE_0000 | addr_i));
          ng++;
        end
        nxt();
      end
      req_i = 1'b0;
      PREADY = 1'b0;
      chk("b2b_grants", 32'(g.size()), 32'd4);
      chk("b2b_rvalids", 32'(r.size()), 32'd4);
      for (int i = 1; i < g.size(); i++)
        chk("b2b_gnt_gap", 32'(g[i] - g[i-1]), 32'd3);
      for (int i = 0; i < r.size() && i < g.size(); i++)
        chk("b2b_latency", 32'(r[i] - g[i]), 32'd3);
      chk("b2b_last_rdata", rdata_o, 32'hC0DE_010C);
    end

    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0ABC;
    PREADY = 1'b0;
    @(negedge HCLK);
    chk("rstx_gnt", 32'(gnt_o), 32'd1);
    nxt();
    req_i = 1'b0;
    nxt();
    nxt();
    #2 HRESETn = 1'b0;
    #1;
    chk("rstx_psel", 32'(PSEL), 32'd0);
    chk("rstx_penable", 32'(PENABLE), 32'd0);
    chk("rstx_paddr", 32'(PADDR), 32'd0);
    chk("rstx_pwdata", PWDATA, 32'd0);
    chk("rstx_pwrite", 32'(PWRITE), 32'd0);
    chk("rstx_rvalid", 32'(rvalid_o), 32'd0);
    chk("rstx_rdata", rdata_o, 32'd0);
    chk("rstx_err", 32'(err_o), 32'd0);
    repeat (2) @(posedge HCLK);
    #2 HRESETn = 1'b1;
    xfer(1'b1, 32'h0000_0ABC, 32'h0BAD_F00D, 0,
         32'h0, 1'b0, 32'h0, 1'b0, 1);

    begin : rnd
      int p;
      bit drop;
      p = 100;
      for (int c = 0; c < 3000; c++) begin
        if (!req_i && $urandom_range(0, 2) == 0) begin
          req_i = 1'b1;
          we_i = 1'($urandom_range(0, 1));
          addr_i = $urandom;
          wdata_i = $urandom;
        end
        PREADY = ($urandom_range(0, 99) < p);
        PRDATA = $urandom;
        PSLVERR = ($urandom_range(0, 4) == 0);
        @(negedge HCLK);
        drop = gnt_o;
        if (gnt_o) begin
          case ($urandom_range(0, 3))
            0: p = 100;
            1: p = 70;
            2: p = 30;
            default: p = 0;
          endcase
        end
        nxt();
        if (drop) req_i = 1'b0;
      end
    end

    req_i = 1'b0;
    PREADY = 1'b1;
    repeat (10) nxt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
